// File: rtl/dpseq_pkg.sv
// Shared types and constants for the dot-product sequencer.
// State enum, data width, default job length and length-width helper.
package dpseq_pkg;

    localparam int DATA_W      = 8;
    localparam int MAX_LEN_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Width needed to hold a pair count from 0 up to max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/dpseq_if.sv
// Operand stream and result stream bundle for the sequencer.
// slave: sequencer side (takes pairs, offers result); master: environment.
interface dpseq_if
    import dpseq_pkg::*;
    ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_weight;
    logic [DATA_W-1:0] in_value;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_overflow;

    modport slave (
        input  in_valid,
        input  in_weight,
        input  in_value,
        output in_ready,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_overflow
    );

    modport master (
        output in_valid,
        output in_weight,
        output in_value,
        input  in_ready,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_overflow
    );

endinterface

// File: rtl/dpseq_counter.sv
// Accepted-pair counter with a captured job length.
// Ports: load (zero count, capture limit), clear, inc; term (count=limit), last (count+1=limit).
module dpseq_counter #(
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             inc,
    input  logic [LEN_W-1:0] limit,
    output logic             term,
    output logic             last
);

    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] lim_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            lim_q <= '0;
        end else if (clear) begin
            count <= '0;
            lim_q <= '0;
        end else if (load) begin
            count <= '0;
            lim_q <= limit;
        end else if (inc) begin
            count <= count + LEN_W'(1);
        end
    end

    assign term = (count == lim_q);
    // Next accepted pair completes the job.
    assign last = ((count + LEN_W'(1)) == lim_q);

endmodule

// File: rtl/dot_product_sequencer.sv
// Drives an external MAC over a streamed weight/value vector, one result per job.
// Ports: clk/rst, job control (start, abort, float_mode, length, bias),
// io (operand/result streams), mac_* (MAC operands and result), busy.
// Build option: DPSEQ_OVF_FREEZE_EN freezes acc after the first MAC overflow.
module dot_product_sequencer
    import dpseq_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              float_mode,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] bias,
    dpseq_if.slave            io,
    output logic [DATA_W-1:0] mac_weight,
    output logic [DATA_W-1:0] mac_value,
    output logic [DATA_W-1:0] mac_cumulative,
    output logic              mac_float,
    input  logic [DATA_W-1:0] mac_out,
    input  logic              mac_overflow,
    output logic              busy
);

    state_t            state;
    logic [DATA_W-1:0] acc;
    logic              ovf;
    logic              op_vld;
    logic [DATA_W-1:0] op_w;
    logic [DATA_W-1:0] op_v;
    logic              mode;
    logic              res_vld;

    logic [LEN_W-1:0]  len_c;
    logic              term;
    logic              last;
    logic              in_rdy;
    logic              hs;
    logic              acc_load;
    logic              job_load;

    assign len_c = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;

    assign in_rdy   = (state == RUN) && !term;
    assign hs       = in_rdy && io.in_valid;
    assign job_load = (state == IDLE) && start;

`ifdef DPSEQ_OVF_FREEZE_EN
    // Once overflowed, keep the saturated sum; pairs still drain through.
    assign acc_load = op_vld && !ovf;
`else
    assign acc_load = op_vld;
`endif

    dpseq_counter #(
        .LEN_W (LEN_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (job_load && !abort),
        .clear (abort),
        .inc   (hs && !abort),
        .limit (len_c),
        .term  (term),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            ovf     <= 1'b0;
            op_vld  <= 1'b0;
            op_w    <= '0;
            op_v    <= '0;
            mode    <= 1'b0;
            res_vld <= 1'b0;
            busy    <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            acc     <= '0;
            ovf     <= 1'b0;
            op_vld  <= 1'b0;
            res_vld <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // Operands registered at a handshake reach the MAC next cycle.
            op_vld <= hs;
            if (hs) begin
                op_w <= io.in_weight;
                op_v <= io.in_value;
            end
            if (op_vld) begin
                ovf <= ovf | mac_overflow;
            end
            if (acc_load) begin
                acc <= mac_out;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode   <= float_mode;
                        acc    <= bias;
                        ovf    <= 1'b0;
                        op_vld <= 1'b0;
                        busy   <= 1'b1;
                        if (len_c == '0) begin
                            state   <= DONE;
                            res_vld <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (hs && last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state   <= DONE;
                    res_vld <= 1'b1;
                end
                DONE: begin
                    if (io.res_ready) begin
                        state   <= IDLE;
                        res_vld <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign mac_weight     = op_vld ? op_w : '0;
    assign mac_value      = op_vld ? op_v : '0;
    assign mac_cumulative = acc;
    assign mac_float      = mode;

    assign io.in_ready     = in_rdy;
    assign io.res_valid    = res_vld;
    assign io.res_data     = res_vld ? acc : '0;
    assign io.res_overflow = res_vld ? ovf : 1'b0;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Testbench for dot_product_sequencer with an attached MAC model.
// Jobs are checked against a pair-by-pair fold of the MAC function.
module tb_dot_product_sequencer;

    localparam int MAX_LEN = 64;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       float_mode;
    logic [6:0] length;
    logic [7:0] bias;
    logic [7:0] mac_weight;
    logic [7:0] mac_value;
    logic [7:0] mac_cumulative;
    logic       mac_float;
    logic [7:0] mac_out;
    logic       mac_overflow;
    logic       busy;
    logic [8:0] mac_res;

    int checks = 0;
    int errors = 0;

    logic [7:0] wq[$];
    logic [7:0] vq[$];

    dpseq_if sif ();

    dot_product_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .float_mode     (float_mode),
        .length         (length),
        .bias           (bias),
        .io             (sif),
        .mac_weight     (mac_weight),
        .mac_value      (mac_value),
        .mac_cumulative (mac_cumulative),
        .mac_float      (mac_float),
        .mac_out        (mac_out),
        .mac_overflow   (mac_overflow),
        .busy           (busy)
    );

    // int8: saturating signed w*v+c. Mini-float: simple wrapping
    // stand-in; the sequencer never looks inside the format.
    function automatic logic [8:0] mac_fn(
        input logic [7:0] w,
        input logic [7:0] v,
        input logic [7:0] c,
        input logic       fm
    );
        int p;
        logic [7:0] r;
        logic o;
        if (!fm) begin
            p = int'($signed(w)) * int'($signed(v)) + int'($signed(c));
            o = (p > 127) || (p < -128);
            if (p > 127) p = 127;
            if (p < -128) p = -128;
        end else begin
            p = int'(w) * int'(v) + int'(c);
            o = (p > 255);
        end
        r = p[7:0];
        return {o, r};
    endfunction

    assign mac_res      = mac_fn(mac_weight, mac_value, mac_cumulative, mac_float);
    assign mac_out      = mac_res[7:0];
    assign mac_overflow = mac_res[8];

    function automatic logic [8:0] ref_dot(
        input bit fm,
        input logic [7:0] b,
        input int n
    );
        logic [7:0] a;
        logic o;
        logic [8:0] r;
        a = b;
        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            r = mac_fn(wq[i], vq[i], a, fm);
`ifdef DPSEQ_OVF_FREEZE_EN
            if (!o) a = r[7:0];
`else
            a = r[7:0];
`endif
            o = o | r[8];
        end
        return {o, a};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(
        input string tag,
        input bit fm,
        input int len,
        input logic [7:0] b,
        input bit alt,
        input int hold,
        input bit poke,
        input logic [7:0] exp_d,
        input bit exp_o
    );
        int n;
        int sent;
        int cyc;
        bit hs;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        start = 1'b1;
        float_mode = fm;
        length = 7'(len);
        bias = b;
        tick();
        start = 1'b0;
        float_mode = ~fm;
        bias = 8'hAA;
        chk({tag, "/busy"}, busy, 1);
        chk({tag, "/mfloat0"}, mac_float, fm);
        if (n == 0) chk({tag, "/no_rdy"}, sif.in_ready, 0);
        sent = 0;
        cyc = 0;
        while (sent < n && cyc < 4 * n + 8) begin
            sif.in_valid = alt ? (cyc % 2 == 0) : 1'b1;
            sif.in_weight = wq[sent];
            sif.in_value = vq[sent];
            start = poke && (cyc == 1);
            hs = sif.in_valid && sif.in_ready;
            tick();
            if (hs) sent++;
            cyc++;
            chk({tag, "/mfloat"}, mac_float, fm);
        end
        sif.in_valid = 1'b0;
        start = 1'b0;
        chk({tag, "/sent"}, sent, n);
        if (!alt && n > 0) chk({tag, "/bubbles"}, cyc, n);
        if (n > 0) begin
            chk({tag, "/drain"}, sif.res_valid, 0);
            tick();
        end
        chk({tag, "/rvalid"}, sif.res_valid, 1);
        chk({tag, "/rdata"}, sif.res_data, exp_d);
        chk({tag, "/rovf"}, sif.res_overflow, exp_o);
        chk({tag, "/mfloatd"}, mac_float, fm);
        sif.res_ready = 1'b0;
        repeat (hold) begin
            tick();
            chk({tag, "/hold_v"}, sif.res_valid, 1);
            chk({tag, "/hold_d"}, sif.res_data, exp_d);
        end
        sif.res_ready = 1'b1;
        tick();
        sif.res_ready = 1'b0;
        chk({tag, "/rv_clr"}, sif.res_valid, 0);
        chk({tag, "/idle"}, busy, 0);
    endtask

    task automatic rand_job(input string tag, input int len);
        int n;
        bit fm;
        logic [7:0] b;
        logic [8:0] e;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        wq.delete();
        vq.delete();
        for (int i = 0; i < n; i++) begin
            wq.push_back(8'($urandom));
            vq.push_back(8'($urandom_range(0, 15)));
        end
        fm = 1'($urandom_range(0, 1));
        b = 8'($urandom);
        e = ref_dot(fm, b, n);
        run_job(tag, fm, len, b, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 1'b1, e[7:0], e[8]);
    endtask

    initial begin
        logic [8:0] e;
        logic [8:0] e2;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        float_mode = 1'b0;
        length = '0;
        bias = '0;
        sif.in_valid = 1'b0;
        sif.in_weight = '0;
        sif.in_value = '0;
        sif.res_ready = 1'b0;
        #12;
        chk("rst/in_ready", sif.in_ready, 0);
        chk("rst/res_valid", sif.res_valid, 0);
        chk("rst/res_data", sif.res_data, 0);
        chk("rst/res_ovf", sif.res_overflow, 0);
        chk("rst/busy", busy, 0);
        chk("rst/mac_w", mac_weight, 0);
        chk("rst/mac_v", mac_value, 0);
        chk("rst/mac_c", mac_cumulative, 0);
        chk("rst/mac_f", mac_float, 0);
        rst = 1'b0;
        tick();

        wq = '{8'd2, 8'hFC, 8'd1};
        vq = '{8'd3, 8'd5, 8'd7};
        run_job("basic", 1'b0, 3, 8'h00, 1'b0, 0, 1'b0, 8'hF9, 1'b0);

        wq.delete();
        vq.delete();
        run_job("len0", 1'b0, 0, 8'h15, 1'b0, 0, 1'b0, 8'h15, 1'b0);

        wq = '{8'd100, 8'hFF};
        vq = '{8'd2, 8'd1};
`ifdef DPSEQ_OVF_FREEZE_EN
        run_job("ovf", 1'b0, 2, 8'h00, 1'b0, 0, 1'b0, 8'h7F, 1'b1);
`else
        run_job("ovf", 1'b0, 2, 8'h00, 1'b0, 0, 1'b0, 8'h7E, 1'b1);
`endif

        wq = '{8'd7, 8'hF6, 8'd3, 8'd9};
        vq = '{8'd4, 8'd2, 8'hFB, 8'd1};
        e = ref_dot(1'b0, 8'h05, 4);
        run_job("cont", 1'b0, 4, 8'h05, 1'b0, 0, 1'b0, e[7:0], e[8]);
        e2 = ref_dot(1'b0, 8'h05, 4);
        run_job("alt", 1'b0, 4, 8'h05, 1'b1, 3, 1'b1, e2[7:0], e2[8]);

        wq = '{8'd3, 8'd5, 8'd2};
        vq = '{8'd7, 8'd11, 8'd9};
        e = ref_dot(1'b1, 8'h20, 3);
        run_job("float", 1'b1, 3, 8'h20, 1'b0, 1, 1'b1, e[7:0], e[8]);

        // Abort after two of five pairs.
        start = 1'b1;
        float_mode = 1'b0;
        length = 7'd5;
        bias = 8'h07;
        tick();
        start = 1'b0;
        sif.in_valid = 1'b1;
        sif.in_weight = 8'd4;
        sif.in_value = 8'd4;
        tick();
        tick();
        sif.in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort/busy", busy, 0);
        chk("abort/in_ready", sif.in_ready, 0);
        chk("abort/res_valid", sif.res_valid, 0);
        chk("abort/acc", mac_cumulative, 0);
        chk("abort/mac_w", mac_weight, 0);
        repeat (3) tick();
        chk("abort/no_res", sif.res_valid, 0);
        wq = '{8'd3};
        vq = '{8'd3};
        run_job("post_abort", 1'b0, 1, 8'h00, 1'b0, 0, 1'b0, 8'h09, 1'b0);

        for (int j = 0; j < 8; j++) begin
            rand_job("rand", $urandom_range(1, 9));
        end
        rand_job("clamp", 100);

        // Asynchronous reset in the middle of a float job.
        start = 1'b1;
        float_mode = 1'b1;
        length = 7'd6;
        bias = 8'h10;
        tick();
        start = 1'b0;
        sif.in_valid = 1'b1;
        sif.in_weight = 8'd3;
        sif.in_value = 8'd4;
        tick();
        sif.in_weight = 8'd5;
        sif.in_value = 8'd6;
        tick();
        chk("pre_rst/acc", mac_cumulative, 8'h1C);
        #3;
        rst = 1'b1;
        #1;
        chk("arst/in_ready", sif.in_ready, 0);
        chk("arst/busy", busy, 0);
        chk("arst/res_valid", sif.res_valid, 0);
        chk("arst/res_data", sif.res_data, 0);
        chk("arst/mac_f", mac_float, 0);
        chk("arst/mac_c", mac_cumulative, 0);
        chk("arst/mac_w", mac_weight, 0);
        chk("arst/mac_v", mac_value, 0);
        sif.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        chk("arst/idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Sequences the shared 8-bit multiply-accumulate datapath (int8 or 1-4-3 mini-float, combinational, `weight*value + cumulative`) over a streamed vector of weight/value pairs, producing one accumulated dot-product result per job. It sits between an operand stream source, such as a weight/activation buffer reader, and a result consumer. The MAC itself stays outside this block. The sequencer drives the MAC operands, feeds back the running sum, and tracks overflow.

## Interface
Parameters:
- MAX_LEN, 64, maximum pairs per job.
- LEN_W, $clog2(MAX_LEN+1), width of the length field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  cancel the job; takes effect from any state.
- float_mode  in  1  job format (0 = int8, 1 = mini-float); captured at start.
- length  in  LEN_W  pair count; captured at start; values above MAX_LEN clamp to MAX_LEN.
- bias  in  8  initial accumulator value; captured at start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts a pair.
- in_weight, in_value  in  8 each  operand pair.
- mac_weight, mac_value, mac_cumulative  out  8 each  MAC operands.
- mac_float  out  1  MAC mode select.
- mac_out  in  8  MAC result.
- mac_overflow  in  1  MAC overflow flag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  final accumulator value.
- res_overflow  out  1  sticky OR of mac_overflow over the job.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1:
  - Capture length, float_mode and bias.
  - Set acc=bias, count=0, ovf=0, op_vld=0.
  - Go to RUN if length≠0; go to DONE if length=0.
- RUN:
  - in_ready=1 while count<length.
  - On a handshake, load the op regs, set op_vld=1 and increment count.
  - When the handshake makes count=length, go to DRAIN.
- Accumulate: every cycle with op_vld=1, do acc<=mac_out and ovf<=ovf|mac_overflow.
  - op_vld clears when no handshake occurs that cycle.
- DRAIN: perform the final accumulate, then go to DONE.
- DONE:
  - res_valid=1, res_data=acc, res_overflow=ovf.
  - Outputs stay stable until res_ready=1, then return to IDLE.
- MAC drive:
  - mac_weight and mac_value come from the op regs, or 0 when op_vld=0.
  - mac_cumulative=acc.
  - mac_float is the captured float_mode, held for the whole job.
- start outside IDLE is ignored.
- abort has priority over all other inputs. On the next edge: go to IDLE, clear op_vld, acc=0, ovf=0; no result is produced.
- All arithmetic happens in the MAC. The sequencer never modifies acc other than by loading bias, loading mac_out, or clearing.

## Timing
- Reset values: state=IDLE, acc=0, count=0, op_vld=0, ovf=0.
  - in_ready=0, res_valid=0, res_data=0, res_overflow=0, busy=0.
  - mac_weight=0, mac_value=0, mac_cumulative=0, mac_float=0.
- Throughput: one pair per cycle with no bubbles while in_valid stays high.
- Latency from the start edge:
  - length=0: res_valid=1 from the first edge after the start edge.
  - Otherwise, if the last handshake completes at edge N, res_valid=1 from edge N+1 (DRAIN cycle, then DONE).
- The earliest new start is sampled in the cycle after the res handshake edge; no back-to-back overlap.
- in_ready is a function of state and count only, never of in_valid.
- Reset mid-job: immediately returns to the reset values; the operand source must drop its partial vector.

## Configuration
- Macro: DPSEQ_OVF_FREEZE_EN.
- Defined:
  - After the first accumulate with mac_overflow=1, acc holds its value (the saturated result) for the rest of the job.
  - Remaining pairs are still accepted and discarded, so stream alignment is preserved.
- Undefined: every accumulate loads mac_out regardless of overflow.
- res_overflow behaves the same in both builds.

## Structure
- Package dpseq_pkg holds:
  - the state enum type;
  - the DATA_W=8 constant;
  - the MAX_LEN default;
  - the LEN_W derivation function.
- One natural sub-module, dpseq_counter:
  - counts accepted pairs;
  - provides load/clear inputs and a terminal flag (count=length).
- Operand regs and the FSM live in the top module.

## Test plan
- int8, length=3, bias=0, pairs (2,3), (-4,5), (1,7) -> res_data=8'hF9, res_overflow=0, res_valid at the edge after the last handshake plus one.
- length=0, bias=8'h15 -> res_valid the cycle after start, res_data=8'h15, no in_ready pulse.
- int8, length=2, bias=0, pairs (100,2), (-1,1) -> without the macro, res_data=8'h7E and res_overflow=1; with DPSEQ_OVF_FREEZE_EN, res_data=8'h7F and res_overflow=1.
- Backpressure:
  - in_valid alternating 1/0 for length=4 gives the same result as a continuous stream;
  - res_ready held low 3 cycles keeps res_valid=1 and res_data stable;
  - start pulsed during RUN is ignored.
- abort asserted after 2 of 5 pairs -> IDLE next edge, in_ready=0, no res_valid; a following job with bias=0 and pair (3,3) gives 8'h09.
- float_mode=1 job -> mac_float=1 for every cycle from start to the res handshake; rst asserted mid-RUN clears all outputs asynchronously.
